morse_key_timer: RTL and testbench
==================================

MORSE_KEY_TIMER -- requirements
Module: morse_key_timer

Interface
REQ-001 SHALL have parameter DIV, default 10, in_clk cycles per Morse unit tick (legal range 2..65535).
REQ-002 SHALL have parameter DASH_UNITS, default 2, minimum mark length in units classified as dash.
REQ-003 SHALL have parameter LETTER_GAP, default 3, space length in units that emits a letter gap.
REQ-004 SHALL have parameter WORD_GAP, default 7, space length in units that emits a word gap (WORD_GAP > LETTER_GAP).
REQ-005 SHALL have parameter CNT_W, default 16, unit counter width.
REQ-006 in_clk  input  1  single system clock; all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-008 en  input  1  block enable.
REQ-009 key_in  input  1  key level, already synchronized to in_clk (1 = pressed).
REQ-010 sym_ready  input  1  consumer accepts sym_code when high together with sym_valid.
REQ-011 sym_valid  output  1  symbol pending.
REQ-012 sym_code  output  2  0 = dot, 1 = dash, 2 = letter gap, 3 = word gap.
REQ-013 tick  output  1  one-cycle unit-tick strobe.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.
REQ-015 overflow  output  1  sticky flag, symbol dropped.

Function
REQ-016 Prescaler SHALL count 0..DIV-1 while en=1 and FSM not IDLE; tick SHALL pulse in the cycle the count equals DIV-1, and the count SHALL then wrap to 0.
REQ-017 Prescaler and unit counter SHALL clear to 0 on every detected key edge, so the first tick falls DIV cycles after the edge.
REQ-018 Edges SHALL be detected against a registered copy key_q: rise = key_in & ~key_q, fall = ~key_in & key_q.
REQ-019 Unit counter SHALL increment on tick and saturate at 2^CNT_W-1.
REQ-020 FSM states: IDLE, MARK, SPACE.
REQ-021 IDLE -> MARK on rise; no other transition out of IDLE.
REQ-022 On fall in MARK: units < DASH_UNITS emits dot, otherwise emits dash; next state SPACE.
REQ-023 SPACE: emit letter gap exactly once when units reaches LETTER_GAP; emit word gap and go to IDLE when units reaches WORD_GAP.
REQ-024 Rise in SPACE SHALL go to MARK; any gap symbol not yet emitted is not emitted.
REQ-025 Emitted symbols SHALL appear on sym_valid/sym_code in the cycle after the triggering edge or tick.
REQ-026 Output is a one-entry buffer: sym_valid and sym_code SHALL hold stable until a cycle with sym_valid & sym_ready.
REQ-027 If a new symbol arrives while the buffer is full and sym_ready=0, the new symbol SHALL be dropped, the buffered one retained, and overflow set.
REQ-028 Accept and a new symbol in the same cycle SHALL load the new symbol without setting overflow.
REQ-029 en=0 SHALL force the FSM to IDLE and clear prescaler and unit counter, with tick=0; the buffered symbol and overflow SHALL be retained.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 While rst=0, all outputs SHALL be 0 (sym_valid, sym_code, tick, busy, overflow), the FSM SHALL be IDLE, and counters and key_q SHALL be 0.
REQ-032 Reset asserted mid-symbol SHALL discard the in-progress measurement and the buffered symbol.
REQ-033 Reset SHALL be released synchronously to in_clk by the system; the first edge detection is valid on the first cycle after release.

Configuration
REQ-034 Macro MORSE_GLITCH_FILTER_EN defined: a fall in MARK with units = 0 SHALL emit nothing and return to IDLE.
REQ-035 Macro MORSE_GLITCH_FILTER_EN undefined: such a fall SHALL emit a dot per REQ-022.

Verification
REQ-036 DIV=10, sym_ready=1, key high 15 cycles -> sym_code=0 (dot), sym_valid for 1 cycle, 1 cycle after fall.
REQ-037 Key high 35 cycles -> sym_code=1 (dash); key then low 30 cycles -> sym_code=2 one cycle after the third tick.
REQ-038 Key low 75 cycles after a dot -> codes 2 then 3 in order; busy falls with the word gap; tick stops.
REQ-039 sym_ready=0, then a dot, then a dash -> sym_valid=1, sym_code=0 held, overflow=1; raising sym_ready accepts the dot, and the dash is lost.
REQ-040 Key high 5 cycles -> no symbol and busy=0 with MORSE_GLITCH_FILTER_EN; dot without it.
REQ-041 rst=0 pulse during MARK at cycle 20 -> all outputs 0 next cycle; a subsequent 15-cycle press yields a dot.

Source files
------------

// File: rtl/morse_key_timer_if.sv
// Symbol handshake between the Morse key timer (master) and its consumer (slave).
interface morse_key_timer_if;
  logic       sym_valid;
  logic       sym_ready;
  logic [1:0] sym_code;

  modport master (output sym_valid, output sym_code, input sym_ready);
  modport slave  (input sym_valid, input sym_code, output sym_ready);
endinterface

// File: rtl/morse_key_timer.sv
// Morse key timer: measures key marks/spaces in unit ticks and emits dot/dash/gap symbols.
// Optional macro MORSE_GLITCH_FILTER_EN drops marks shorter than one unit.
module morse_key_timer #(
  parameter int unsigned DIV        = 10,
  parameter int unsigned DASH_UNITS = 2,
  parameter int unsigned LETTER_GAP = 3,
  parameter int unsigned WORD_GAP   = 7,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               in_clk,
  input  logic               rst,
  input  logic               en,
  input  logic               key_in,
  morse_key_timer_if.master  sym_if,
  output logic               tick,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned PRE_W = 16;
  localparam logic [1:0] CODE_DOT    = 2'd0;
  localparam logic [1:0] CODE_DASH   = 2'd1;
  localparam logic [1:0] CODE_LETTER = 2'd2;
  localparam logic [1:0] CODE_WORD   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE} state_t;

  state_t             state_q, state_d;
  logic               key_q;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   units_q, units_d;
  logic               valid_q, valid_d;
  logic [1:0]         code_q, code_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;

  logic               rise_c, fall_c, tick_c, emit_c, accept_c, glitch_c;
  logic [1:0]         emit_code_c;

  // State register
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      key_q   <= 1'b0;
      presc_q <= '0;
      units_q <= '0;
      valid_q <= 1'b0;
      code_q  <= 2'd0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_in;
      presc_q <= presc_d;
      units_q <= units_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Timing, classification and next-state
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    units_d     = units_q;
    emit_c      = 1'b0;
    emit_code_c = CODE_DOT;
    rise_c      = key_in & ~key_q;
    fall_c      = ~key_in & key_q;
    tick_c      = en && (state_q != ST_IDLE) && (presc_q == PRE_W'(DIV - 1));
`ifdef MORSE_GLITCH_FILTER_EN
    glitch_c    = (units_q == '0);
`else
    glitch_c    = 1'b0;
`endif

    if (!en) begin
      state_d = ST_IDLE;
      presc_d = '0;
      units_d = '0;
    end else begin
      if (state_q != ST_IDLE) begin
        presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
        if (tick_c && (units_q != {CNT_W{1'b1}})) units_d = units_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (rise_c) state_d = ST_MARK;
        end
        ST_MARK: begin
          if (fall_c) begin
            if (glitch_c) begin
              state_d = ST_IDLE;
            end else begin
              emit_c      = 1'b1;
              emit_code_c = (units_q < CNT_W'(DASH_UNITS)) ? CODE_DOT : CODE_DASH;
              state_d     = ST_SPACE;
            end
          end
        end
        ST_SPACE: begin
          if (rise_c) begin
            state_d = ST_MARK;
          end else if (tick_c) begin
            // Gap boundaries are hit on the tick that moves units onto the threshold
            if (units_q == CNT_W'(WORD_GAP - 1)) begin
              emit_c      = 1'b1;
              emit_code_c = CODE_WORD;
              state_d     = ST_IDLE;
            end else if (units_q == CNT_W'(LETTER_GAP - 1)) begin
              emit_c      = 1'b1;
              emit_code_c = CODE_LETTER;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (rise_c || fall_c || (state_d == ST_IDLE)) begin
        presc_d = '0;
        units_d = '0;
      end
    end
  end

  // One-entry output buffer with sticky overflow
  always_comb begin
    valid_d  = valid_q;
    code_d   = code_q;
    ovf_d    = ovf_q;
    accept_c = valid_q & sym_if.sym_ready;
    if (accept_c) valid_d = 1'b0;
    if (emit_c) begin
      if (!valid_q || accept_c) begin
        valid_d = 1'b1;
        code_d  = emit_code_c;
      end else begin
        ovf_d = 1'b1;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign sym_if.sym_valid = valid_q;
  assign sym_if.sym_code  = code_q;
  assign tick             = tick_c;
  assign busy             = busy_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_morse_key_timer.sv
// Scoreboard bench for morse_key_timer (DIV=10, default thresholds).
module tb_morse_key_timer;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  logic in_clk;
  logic rst;
  logic en;
  logic key_in;
  logic tick;
  logic busy;
  logic overflow;

  morse_key_timer_if sym_if ();

  morse_key_timer dut (
    .in_clk   (in_clk),
    .rst      (rst),
    .en       (en),
    .key_in   (key_in),
    .sym_if   (sym_if),
    .tick     (tick),
    .busy     (busy),
    .overflow (overflow)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   tick_cnt = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;
  always @(negedge in_clk) if (tick) tick_cnt <= tick_cnt + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input logic [1:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected symbol
  always @(negedge in_clk) begin
    if (rst && sym_if.sym_valid && sym_if.sym_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_sym: got code %0d at cycle %0d, expected no symbol", sym_if.sym_code, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("sym_code", int'(sym_if.sym_code), int'(mon_e.code));
        chk("sym_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int d2;
    int t0;
    rst              = 1'b0;
    en               = 1'b1;
    key_in           = 1'b0;
    sym_if.sym_ready = 1'b1;

    // Reset state
    wait_cyc(3);
    chk("rst_valid", int'(sym_if.sym_valid), 0);
    chk("rst_code", int'(sym_if.sym_code), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b1;
    wait_cyc(2);

    // Dot, then letter and word gap; tick stops afterwards
    t0 = tick_cnt;
    key_in = 1'b1;
    wait_cyc(15);
    key_in = 1'b0;
    d = cyc;
    push(2'd0, d + 1);
    push(2'd2, d + 31);
    push(2'd3, d + 71);
    wait_cyc(1);
    chk("dot_busy", int'(busy), 1);
    wait_cyc(1);
    chk("dot_valid_1cyc", int'(sym_if.sym_valid), 0);
    wait_cyc(78);
    chk("word_busy", int'(busy), 0);
    chk("tick_total", tick_cnt - t0, 8);

    // Dash, letter gap, then a new press cancels the word gap
    key_in = 1'b1;
    wait_cyc(35);
    key_in = 1'b0;
    d = cyc;
    push(2'd1, d + 1);
    push(2'd2, d + 31);
    wait_cyc(40);
    key_in = 1'b1;
    wait_cyc(15);
    key_in = 1'b0;
    push(2'd0, d + 56);
    push(2'd2, d + 86);
    push(2'd3, d + 126);
    wait_cyc(80);
    chk("dash_seq_busy", int'(busy), 0);

    // Sub-unit press
    key_in = 1'b1;
    wait_cyc(5);
    key_in = 1'b0;
    d = cyc;
`ifndef MORSE_GLITCH_FILTER_EN
    push(2'd0, d + 1);
    push(2'd2, d + 31);
    push(2'd3, d + 71);
`endif
    wait_cyc(2);
`ifdef MORSE_GLITCH_FILTER_EN
    chk("glitch_busy", int'(busy), 0);
`else
    chk("glitch_busy", int'(busy), 1);
`endif
    wait_cyc(78);

    // Overflow: dot held, dash dropped
    sym_if.sym_ready = 1'b0;
    key_in = 1'b1;
    wait_cyc(15);
    key_in = 1'b0;
    wait_cyc(5);
    key_in = 1'b1;
    wait_cyc(35);
    key_in = 1'b0;
    d2 = cyc;
    wait_cyc(5);
    chk("ovf_valid", int'(sym_if.sym_valid), 1);
    chk("ovf_code", int'(sym_if.sym_code), 0);
    chk("ovf_flag", int'(overflow), 1);
    push(2'd0, cyc);
    push(2'd2, d2 + 31);
    push(2'd3, d2 + 71);
    sym_if.sym_ready = 1'b1;
    wait_cyc(80);
    chk("ovf_sticky", int'(overflow), 1);

    // Enable drop mid-mark
    key_in = 1'b1;
    wait_cyc(12);
    en = 1'b0;
    wait_cyc(1);
    chk("en_busy", int'(busy), 0);
    chk("en_tick", int'(tick), 0);
    chk("en_ovf_kept", int'(overflow), 1);
    key_in = 1'b0;
    wait_cyc(2);
    en = 1'b1;
    wait_cyc(20);
    chk("en_idle", int'(busy), 0);

    // Reset mid-mark, then a clean dot
    key_in = 1'b1;
    wait_cyc(20);
    rst    = 1'b0;
    key_in = 1'b0;
    wait_cyc(1);
    chk("mid_rst_valid", int'(sym_if.sym_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_tick", int'(tick), 0);
    rst = 1'b1;
    wait_cyc(2);
    key_in = 1'b1;
    wait_cyc(15);
    key_in = 1'b0;
    d = cyc;
    push(2'd0, d + 1);
    push(2'd2, d + 31);
    push(2'd3, d + 71);
    wait_cyc(80);
    chk("final_busy", int'(busy), 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
